sdp_ram_be: RTL

Single-clock simple dual-port RAM with per-lane write enables, a read enable with a valid flag, selectable read latency and a post-reset memory-clear sweep. It replaces ad-hoc RAM instances in packet buffers and lookup tables. Those users need byte-granular updates, deterministic contents after reset and defined read-during-write behaviour. The array is coded so that large instances map to block RAM.

---
 rtl/sdp_ram_pkg.sv | 25 ++
 rtl/sdp_ram_array.sv | 34 +++
 rtl/sdp_ram_be.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sdp_ram_pkg.sv
// sdp_ram_be shared types and helpers.
// Holds the clear FSM state type and the parameter sanity checks.
package sdp_ram_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  function automatic int lanes(input int width, input int lane_w);
    return width / lane_w;
  endfunction

  function automatic bit cfg_ok(
    input int width,
    input int lane_w,
    input int rd_lat,
    input int entries
  );
    return (width % lane_w == 0) &&
           (rd_lat == 1 || rd_lat == 2) &&
           (entries >= 2);
  endfunction

endpackage

// File: rtl/sdp_ram_array.sv
// Lane-masked memory array with a one-cycle registered read.
// No reset on the array or read register so it maps to block RAM.
module sdp_ram_array
  import sdp_ram_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 256,
  parameter int LANE_W  = 8,
  localparam int LANES  = lanes(WIDTH, LANE_W),
  localparam int AW     = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic [LANES-1:0] we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) begin
        mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM with lane strobes, clear sweep and 1/2-cycle reads.
// Define SDP_RAM_BYPASS_EN for write-first same-address collisions.
module sdp_ram_be
  import sdp_ram_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int ENTRIES      = 256,
  parameter int LANE_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  localparam int LANES = lanes(WIDTH, LANE_W),
  localparam int AW    = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic             busy,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [LANES-1:0] write_enable,
  input  logic [AW-1:0]    raddr,
  input  logic             read_enable,
  output logic [WIDTH-1:0] read_data,
  output logic             read_valid
);

  if (!cfg_ok(WIDTH, LANE_W, READ_LATENCY, ENTRIES)) begin : g_cfg_err
    $error("sdp_ram_be: illegal parameter combination");
  end

  localparam logic [AW-1:0] LAST  = AW'(ENTRIES - 1);
  localparam logic [AW:0]   DEPTH = (AW+1)'(ENTRIES);

  state_e        state;
  logic [AW-1:0] clr_addr;

  logic w_in;
  logic r_in;
  logic rd_go;

  assign busy  = (state == CLEAR);
  assign w_in  = {1'b0, waddr} < DEPTH;
  assign r_in  = {1'b0, raddr} < DEPTH;
  assign rd_go = !busy && read_enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (clear) begin
            clr_addr <= '0;
          end else if (clr_addr == LAST) begin
            state    <= READY;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + AW'(1);
          end
        end
        READY: begin
          if (clear) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end
        end
      endcase
    end
  end

  logic [LANES-1:0] a_we;
  logic [AW-1:0]    a_waddr;
  logic [WIDTH-1:0] a_wdata;
  logic [WIDTH-1:0] a_rdata;

  // The sweep owns the write port; user writes are simply masked off.
  always_comb begin
    a_we    = '0;
    a_waddr = waddr;
    a_wdata = write_data;
    if (busy) begin
      a_we    = '1;
      a_waddr = clr_addr;
      a_wdata = INIT_VALUE;
    end else if (w_in) begin
      a_we = write_enable;
    end
  end

  sdp_ram_array #(
    .WIDTH  (WIDTH),
    .ENTRIES(ENTRIES),
    .LANE_W (LANE_W)
  ) u_array (
    .clk  (clk),
    .we   (a_we),
    .waddr(a_waddr),
    .wdata(a_wdata),
    .re   (rd_go && r_in),
    .raddr(raddr),
    .rdata(a_rdata)
  );

  logic v1;
  logic oor1;
  logic seen1;

  // seen1 masks the unreset array register until a read has landed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      oor1  <= 1'b0;
      seen1 <= 1'b0;
    end else begin
      v1 <= rd_go;
      if (rd_go) begin
        oor1  <= !r_in;
        seen1 <= 1'b1;
      end
    end
  end

  logic [WIDTH-1:0] merged;

`ifdef SDP_RAM_BYPASS_EN
  logic             hit1;
  logic [LANES-1:0] be1;
  logic [WIDTH-1:0] wd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit1 <= 1'b0;
      be1  <= '0;
      wd1  <= '0;
    end else if (rd_go) begin
      hit1 <= w_in && (waddr == raddr);
      be1  <= write_enable;
      wd1  <= write_data;
    end
  end

  always_comb begin
    merged = a_rdata;
    for (int i = 0; i < LANES; i++) begin
      if (hit1 && be1[i]) begin
        merged[i*LANE_W +: LANE_W] = wd1[i*LANE_W +: LANE_W];
      end
    end
  end
`else
  assign merged = a_rdata;
`endif

  logic [WIDTH-1:0] d1;

  assign d1 = !seen1 ? '0 : (oor1 ? INIT_VALUE : merged);

  if (READ_LATENCY == 2) begin : g_lat2
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        read_valid <= 1'b0;
        read_data  <= '0;
      end else begin
        read_valid <= v1;
        if (v1) begin
          read_data <= d1;
        end
      end
    end
  end else begin : g_lat1
    assign read_valid = v1;
    assign read_data  = d1;
  end

endmodule
